// File: rtl/mips_multiport_register_file_pkg.sv
// Shared types for the multiport register file: read modes, clear FSM states,
// and the default register address type.
package mips_multiport_register_file_pkg;

  typedef enum logic [1:0] {
    RF_ASYNC       = 2'd0,
    RF_WRITE_FIRST = 2'd1,
    RF_READ_FIRST  = 2'd2
  } rf_mode_e;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_clr_state_e;

  localparam int RF_AWL = 5;

  typedef logic [RF_AWL-1:0] rfa_t;

endpackage

// File: rtl/mips_multiport_register_file_rf_write_arbiter.sv
// Combinational merge of all write ports into per-entry strobes and data.
// Later (higher-index) ports override earlier ones on the same address.
module rf_write_arbiter
  import mips_multiport_register_file_pkg::*;
#(
  parameter int DWL      = 32,
  parameter int AWL      = 5,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  localparam int DEPTH   = 2**AWL
) (
  input  logic [NUM_WR-1:0]           wen,
  input  logic [NUM_WR-1:0][AWL-1:0]  wa,
  input  logic [NUM_WR-1:0][DWL-1:0]  wd,
  output logic [DEPTH-1:0]            wr_stb,
  output logic [DEPTH-1:0][DWL-1:0]   wr_data,
  output logic                        conflict
);

  logic [NUM_WR-1:0] wr_valid;

  // Writes to the hardwired zero entry vanish here, so they never strobe or conflict.
  for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_valid
    assign wr_valid[gi] = wen[gi] && !((ZERO_REG != 0) && (wa[gi] == '0));
  end

  always_comb begin
    wr_stb   = '0;
    wr_data  = '0;
    conflict = 1'b0;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_valid[p]) begin
        if (wr_stb[wa[p]]) begin
          conflict = 1'b1;
        end
        wr_stb[wa[p]]  = 1'b1;
        wr_data[wa[p]] = wd[p];
      end
    end
  end

endmodule

// File: rtl/mips_multiport_register_file.sv
// Parametrised N-read / M-write register file with a post-reset clear sequencer
// and selectable async, write-first or read-first read ports.
module mips_multiport_register_file
  import mips_multiport_register_file_pkg::*;
#(
  parameter int DWL      = 32,
  parameter int AWL      = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int RF_MODE  = 0,
  parameter int ZERO_REG = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_WR-1:0]           wen,
  input  logic [NUM_WR-1:0][AWL-1:0]  WA,
  input  logic [NUM_WR-1:0][DWL-1:0]  WD,
  input  logic [NUM_RD-1:0][AWL-1:0]  RA,
  output logic [NUM_RD-1:0][DWL-1:0]  RD,
  output logic                        ready,
  output logic                        wr_conflict
);

  localparam int DEPTH = 2**AWL;

  rf_clr_state_e           state_reg, state_next;
  logic [AWL-1:0]          clr_ptr_reg, clr_ptr_next;
  logic                    ready_reg;
  logic                    conflict_reg;
  logic                    clr_active;
  logic                    wr_allow;
  logic [DEPTH-1:0]        wr_stb;
  logic [DEPTH-1:0][DWL-1:0] wr_data;
  logic                    arb_conflict;
  logic [DWL-1:0]          rf [DEPTH];

  // ready lags the state by one cycle, so it rises the cycle after the last clear write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= CLEAR;
      clr_ptr_reg  <= '0;
      ready_reg    <= 1'b0;
      conflict_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      clr_ptr_reg  <= clr_ptr_next;
      ready_reg    <= (state_reg == RUN);
      conflict_reg <= arb_conflict;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_ptr_next = clr_ptr_reg;
    case (state_reg)
      CLEAR: begin
        clr_ptr_next = clr_ptr_reg + AWL'(1);
        if (clr_ptr_reg == {AWL{1'b1}}) begin
          state_next = RUN;
        end
      end
      RUN:     state_next = RUN;
      default: state_next = CLEAR;
    endcase
  end

  always_comb begin
    clr_active = rst_n && (state_reg == CLEAR);
    wr_allow   = rst_n && ready_reg;
  end

  rf_write_arbiter #(
    .DWL      (DWL),
    .AWL      (AWL),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_arbiter (
    .wen      (wen & {NUM_WR{wr_allow}}),
    .wa       (WA),
    .wd       (WD),
    .wr_stb   (wr_stb),
    .wr_data  (wr_data),
    .conflict (arb_conflict)
  );

  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (clr_active && (clr_ptr_reg == AWL'(e))) begin
        rf[e] <= '0;
      end else if (wr_stb[e]) begin
        rf[e] <= wr_data[e];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [DWL-1:0] rf_word;

    assign rf_word = ((ZERO_REG != 0) && (RA[gi] == '0)) ? '0 : rf[RA[gi]];

    if (RF_MODE == int'(RF_ASYNC)) begin : g_async
      assign RD[gi] = ready_reg ? rf_word : '0;
    end else begin : g_sync
      logic [DWL-1:0] rd_reg, rd_next;

      // Write-first forwards the winning write data; read-first keeps the pre-edge word.
      always_comb begin
        rd_next = rf_word;
        if ((RF_MODE == int'(RF_WRITE_FIRST)) && wr_stb[RA[gi]]) begin
          rd_next = wr_data[RA[gi]];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rd_reg <= '0;
        end else if (ready_reg) begin
          rd_reg <= rd_next;
        end
      end

      assign RD[gi] = ready_reg ? rd_reg : '0;
    end
  end

  assign ready       = ready_reg;
  assign wr_conflict = conflict_reg;

endmodule

// File: tb/tb_mips_multiport_register_file.sv
// Self-checking bench: three register files (async, write-first, read-first)
// share one stimulus stream and are checked against an array-based model.
module tb_mips_multiport_register_file;
  import mips_multiport_register_file_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [1:0]           wen = '0;
  logic [1:0][4:0]      wa = '0;
  logic [1:0][31:0]     wd = '0;
  logic [3:0][4:0]      ra = '0;
  logic [3:0][31:0]     rd_m [3];
  logic [2:0]           rdy;
  logic [2:0]           conf;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    mips_multiport_register_file #(
      .DWL      (32),
      .AWL      (5),
      .NUM_RD   (4),
      .NUM_WR   (2),
      .RF_MODE  (gi),
      .ZERO_REG (1)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wen         (wen),
      .WA          (wa),
      .WD          (wd),
      .RA          (ra),
      .RD          (rd_m[gi]),
      .ready       (rdy[gi]),
      .wr_conflict (conf[gi])
    );
  end

  // Reference model: plain memory image plus a ready flag driven by a cycle count.
  logic [31:0] mem [32];
  bit          mdl_ready;
  int          clr_cnt;
  int          n_checks = 0;
  int          n_fail = 0;

  logic [31:0] obs_m0_pre, obs_m0_post, obs_m1, obs_m2;
  logic        obs_conf;

  typedef struct {
    logic [1:0]  w;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    logic [4:0]  r0;
    logic [31:0] e_pre, e_wf, e_rf;
    logic        e_conf;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wen   = '0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    mdl_ready = 1'b0;
    clr_cnt   = 0;
    for (int k = 0; k < 32; k++) mem[k] = '0;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_ready[%0d]", d), 32'(rdy[d]), 32'd0);
      check($sformatf("reset_conflict[%0d]", d), 32'(conf[d]), 32'd0);
    end
  endtask

  // One clock of stimulus: mode 0 sampled before the edge, everything after it.
  task automatic run_cycle(input logic [1:0] w, input logic [4:0] a0, input logic [4:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input logic [4:0] r0, input logic [4:0] r1,
                           input logic [4:0] r2, input logic [4:0] r3);
    logic [3:0][31:0] exp_pre, exp_wf;
    logic             exp_conf;
    logic [4:0]       addr [2];
    logic [31:0]      data [2];
    wen = w; wa[0] = a0; wa[1] = a1; wd[0] = d0; wd[1] = d1;
    ra[0] = r0; ra[1] = r1; ra[2] = r2; ra[3] = r3;
    addr[0] = a0; addr[1] = a1; data[0] = d0; data[1] = d1;
    @(negedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_pre[i] = mdl_ready ? mem[ra[i]] : 32'd0;
      check($sformatf("m0_pre[%0d] ra=%0d", i, ra[i]), rd_m[0][i], exp_pre[i]);
    end
    obs_m0_pre = rd_m[0][0];
    exp_conf = mdl_ready && (w == 2'b11) && (a0 == a1) && (a0 != 5'd0);
    if (mdl_ready) begin
      for (int p = 0; p < 2; p++) begin
        if (w[p] && addr[p] != 5'd0) mem[addr[p]] = data[p];
      end
    end
    for (int i = 0; i < 4; i++) exp_wf[i] = mdl_ready ? mem[ra[i]] : 32'd0;
    if (!mdl_ready) begin
      clr_cnt++;
      if (clr_cnt == 33) mdl_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("m0_post[%0d] ra=%0d", i, ra[i]), rd_m[0][i],
            mdl_ready ? mem[ra[i]] : 32'd0);
      check($sformatf("m1[%0d] ra=%0d", i, ra[i]), rd_m[1][i], exp_wf[i]);
      check($sformatf("m2[%0d] ra=%0d", i, ra[i]), rd_m[2][i], exp_pre[i]);
    end
    for (int d = 0; d < 3; d++) begin
      check($sformatf("conflict[%0d]", d), 32'(conf[d]), 32'(exp_conf));
      check($sformatf("ready[%0d]", d), 32'(rdy[d]), 32'(mdl_ready));
    end
    obs_m0_post = rd_m[0][0];
    obs_m1      = rd_m[1][0];
    obs_m2      = rd_m[2][0];
    obs_conf    = conf[1];
  endtask

  task automatic wait_clear(input string name, input logic [1:0] w);
    int lat;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      run_cycle(w, 5'd5, 5'd6, 32'hDEAD_0005, 32'hBEEF_0006,
                5'($urandom_range(0, 31)), 5'd5, 5'd6, 5'd0);
      if (rdy == 3'b111) begin
        lat = n;
        break;
      end
    end
    check(name, 32'(lat), 32'd33);
    $display("%s: ready after %0d cycles", name, lat);
  endtask

  initial begin
    vecs[0] = '{2'b01, 5'd3, 5'd0, 32'h11,        32'h0,        5'd3, 32'h0,  32'h11, 32'h0,  1'b0};
    vecs[1] = '{2'b01, 5'd3, 5'd0, 32'hAA,        32'h0,        5'd3, 32'h11, 32'hAA, 32'h11, 1'b0};
    vecs[2] = '{2'b00, 5'd3, 5'd0, 32'h0,         32'h0,        5'd3, 32'hAA, 32'hAA, 32'hAA, 1'b0};
    vecs[3] = '{2'b11, 5'd7, 5'd7, 32'h33,        32'h22,       5'd7, 32'h0,  32'h22, 32'h0,  1'b1};
    vecs[4] = '{2'b00, 5'd7, 5'd7, 32'h0,         32'h0,        5'd7, 32'h22, 32'h22, 32'h22, 1'b0};
    vecs[5] = '{2'b01, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h0,        5'd0, 32'h0,  32'h0,  32'h0,  1'b0};
    vecs[6] = '{2'b11, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'h0, 32'h0,  32'h0,  1'b0};
    vecs[7] = '{2'b01, 5'd5, 5'd0, 32'h55,        32'h0,        5'd5, 32'h0,  32'h55, 32'h0,  1'b0};

    do_reset();
    wait_clear("clear_latency", 2'b00);

    for (int k = 0; k < 8; k++) begin
      run_cycle(2'b00, 5'd0, 5'd0, 32'h0, 32'h0,
                5'(4*k), 5'(4*k+1), 5'(4*k+2), 5'(4*k+3));
      $display("zero sweep entries %0d..%0d checked", 4*k, 4*k+3);
    end

    for (int v = 0; v < 8; v++) begin
      run_cycle(vecs[v].w, vecs[v].a0, vecs[v].a1, vecs[v].d0, vecs[v].d1,
                vecs[v].r0, 5'd3, 5'd7, 5'd5);
      check($sformatf("vec%0d m0_pre", v), obs_m0_pre, vecs[v].e_pre);
      check($sformatf("vec%0d m0_post", v), obs_m0_post, vecs[v].e_wf);
      check($sformatf("vec%0d m1", v), obs_m1, vecs[v].e_wf);
      check($sformatf("vec%0d m2", v), obs_m2, vecs[v].e_rf);
      check($sformatf("vec%0d conflict", v), 32'(obs_conf), 32'(vecs[v].e_conf));
      $display("vec%0d: m0 %h/%h m1 %h m2 %h conflict %0b",
               v, obs_m0_pre, obs_m0_post, obs_m1, obs_m2, obs_conf);
    end

    // Mid-run reset with rf[5]=0x55; writes during the clear must be dropped.
    do_reset();
    wait_clear("reclear_latency", 2'b11);
    run_cycle(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd6, 5'd3, 5'd7);
    check("rf5_after_reclear", obs_m0_pre, 32'h0);
    $display("rf[5] after reclear = %h", obs_m0_pre);

    for (int t = 0; t < 300; t++) begin
      run_cycle(2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                $urandom, $urandom,
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 7)));
      $display("rand %0d: wen=%b wa=%0d/%0d ra0=%0d m1=%h", t, wen, wa[0], wa[1], ra[0], obs_m1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
